// File: rtl/xgmii_pkg.sv
// Shared XGMII constants and encodings for the link fault sequence tracker.
package xgmii_pkg;

    localparam logic [7:0]  SEQ_CHAR        = 8'h9C;
    localparam logic [7:0]  SEQ_LOCAL_CODE  = 8'h01;
    localparam logic [7:0]  SEQ_REMOTE_CODE = 8'h02;
    localparam logic [7:0]  IDLE_CHAR       = 8'h07;
    localparam logic [63:0] IDLE_WORD       = {8{IDLE_CHAR}};
    localparam logic [7:0]  IDLE_CTRL       = 8'hFF;

    typedef enum logic [1:0] {
        SEQ_NONE   = 2'd0,
        SEQ_LOCAL  = 2'd1,
        SEQ_REMOTE = 2'd2
    } seq_type_t;

    typedef enum logic [1:0] {
        LINK_OK     = 2'd0,
        LINK_LOCAL  = 2'd1,
        LINK_REMOTE = 2'd2
    } link_fault_t;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_COUNT = 2'd1,
        ST_FAULT = 2'd2
    } lf_state_t;

    function automatic link_fault_t seq_to_fault(input seq_type_t t);
        return (t == SEQ_REMOTE) ? LINK_REMOTE : LINK_LOCAL;
    endfunction

endpackage

// File: rtl/xgmii_seq_decode.sv
// Classifies one 32-bit XGMII column as a local/remote fault ordered set or not.
module xgmii_seq_decode
    import xgmii_pkg::*;
(
    input  logic [31:0] col_rxd,
    input  logic [3:0]  col_rxc,
    output logic [1:0]  seq_type
);

    // Only lane 0 may be a control character; lanes 1-2 must be zero.
    always_comb begin
        seq_type = SEQ_NONE;
        if (col_rxc == 4'b0001 && col_rxd[7:0] == SEQ_CHAR &&
            col_rxd[15:8] == 8'h00 && col_rxd[23:16] == 8'h00) begin
            if (col_rxd[31:24] == SEQ_LOCAL_CODE) begin
                seq_type = SEQ_LOCAL;
            end else if (col_rxd[31:24] == SEQ_REMOTE_CODE) begin
                seq_type = SEQ_REMOTE;
            end
        end
    end

endmodule

// File: rtl/xgmii_link_fault.sv
// XGMII RX link fault state machine: two column updates per clk156 cycle,
// registered fault flags, a saturating fault event counter and a 1-cycle RX delay.
module xgmii_link_fault
    import xgmii_pkg::*;
#(
    parameter int C_COL_WINDOW = 128,
    parameter int C_CNT_W      = 16
) (
    input  logic               clk156,
    input  logic               reset,
    input  logic               rx_reset,
    input  logic [63:0]        xgmii_rxd,
    input  logic [7:0]         xgmii_rxc,
    output logic [63:0]        xgmii_rxd_out,
    output logic [7:0]         xgmii_rxc_out,
    output logic               local_fault,
    output logic               remote_fault,
    output logic [C_CNT_W-1:0] fault_cnt,
    input  logic               clr_cnt
);

    localparam int               COL_W   = $clog2(C_COL_WINDOW + 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(C_COL_WINDOW);

    typedef struct packed {
        lf_state_t        state;
        seq_type_t        last_type;
        logic [1:0]       seq_cnt;
        logic [COL_W-1:0] col_cnt;
        link_fault_t      link_fault;
    } track_t;

    function automatic track_t reset_track();
        track_t r;
        r.state      = ST_INIT;
        r.last_type  = SEQ_LOCAL;
        r.seq_cnt    = 2'd0;
        r.col_cnt    = '0;
        r.link_fault = LINK_OK;
        return r;
    endfunction

    // One column's worth of state update; applied twice per cycle (A then B).
    function automatic track_t col_step(input track_t cur, input seq_type_t t);
        track_t nxt;
        nxt = cur;
        case (cur.state)
            ST_INIT: begin
                if (t != SEQ_NONE) begin
                    nxt.state     = ST_COUNT;
                    nxt.last_type = t;
                    nxt.seq_cnt   = 2'd1;
                    nxt.col_cnt   = '0;
                end
            end
            ST_COUNT, ST_FAULT: begin
                if (t == SEQ_NONE) begin
                    if (cur.col_cnt < COL_MAX) begin
                        nxt.col_cnt = cur.col_cnt + COL_W'(1);
                    end
                    if (nxt.col_cnt == COL_MAX) begin
                        nxt.state   = ST_INIT;
                        nxt.seq_cnt = 2'd0;
                        if (cur.state == ST_FAULT) begin
                            nxt.link_fault = LINK_OK;
                        end
                    end
                end else if (t == cur.last_type) begin
                    nxt.col_cnt = '0;
                    if (cur.state == ST_COUNT) begin
                        if (cur.seq_cnt < 2'd3) begin
                            nxt.seq_cnt = cur.seq_cnt + 2'd1;
                        end else begin
                            nxt.link_fault = seq_to_fault(t);
                            nxt.state      = ST_FAULT;
                        end
                    end
                end else begin
                    // A type change restarts counting but keeps any declared fault.
                    nxt.state     = ST_COUNT;
                    nxt.last_type = t;
                    nxt.seq_cnt   = 2'd1;
                    nxt.col_cnt   = '0;
                end
            end
            default: nxt = reset_track();
        endcase
        return nxt;
    endfunction

    logic [1:0] type_a_raw;
    logic [1:0] type_b_raw;
    seq_type_t  type_a;
    seq_type_t  type_b;
    track_t     track_q;
    track_t     after_a;
    track_t     track_d;
    logic       fault_event;

    xgmii_seq_decode u_decode_a (
        .col_rxd  (xgmii_rxd[31:0]),
        .col_rxc  (xgmii_rxc[3:0]),
        .seq_type (type_a_raw)
    );

    xgmii_seq_decode u_decode_b (
        .col_rxd  (xgmii_rxd[63:32]),
        .col_rxc  (xgmii_rxc[7:4]),
        .seq_type (type_b_raw)
    );

    assign type_a = seq_type_t'(type_a_raw);
    assign type_b = seq_type_t'(type_b_raw);

    always_comb begin
        after_a     = col_step(track_q, type_a);
        track_d     = col_step(after_a, type_b);
        fault_event = (track_d.link_fault != LINK_OK) &&
                      (track_d.link_fault != track_q.link_fault);
    end

    // Flags are decoded from the next state so they line up with track_q.
    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            track_q       <= reset_track();
            local_fault   <= 1'b0;
            remote_fault  <= 1'b0;
            fault_cnt     <= '0;
            xgmii_rxd_out <= IDLE_WORD;
            xgmii_rxc_out <= IDLE_CTRL;
        end else if (rx_reset) begin
            track_q       <= reset_track();
            local_fault   <= 1'b0;
            remote_fault  <= 1'b0;
            fault_cnt     <= '0;
            xgmii_rxd_out <= IDLE_WORD;
            xgmii_rxc_out <= IDLE_CTRL;
        end else begin
            track_q       <= track_d;
            local_fault   <= (track_d.link_fault == LINK_LOCAL);
            remote_fault  <= (track_d.link_fault == LINK_REMOTE);
            xgmii_rxd_out <= xgmii_rxd;
            xgmii_rxc_out <= xgmii_rxc;
            if (clr_cnt) begin
                fault_cnt <= '0;
            end else if (fault_event && (fault_cnt != {C_CNT_W{1'b1}})) begin
                fault_cnt <= fault_cnt + C_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_xgmii_link_fault.sv
// Directed bench for xgmii_link_fault; a second instance with a 2-bit counter
// exercises fault_cnt saturation without tens of thousands of faults.
module tb_xgmii_link_fault;

    localparam logic [35:0] COL_IDLE   = {4'hF, 32'h07070707};
    localparam logic [35:0] COL_LOCAL  = {4'h1, 32'h0100009C};
    localparam logic [35:0] COL_REMOTE = {4'h1, 32'h0200009C};
    localparam logic [35:0] COL_BAD    = {4'h1, 32'h0300009C};
    localparam logic [63:0] IDLE_WORD  = 64'h0707070707070707;

    logic        clk156 = 1'b0;
    logic        reset;
    logic        rx_reset;
    logic        clr_cnt;
    logic [63:0] xgmii_rxd;
    logic [7:0]  xgmii_rxc;
    logic [63:0] xgmii_rxd_out;
    logic [7:0]  xgmii_rxc_out;
    logic        local_fault;
    logic        remote_fault;
    logic [15:0] fault_cnt;
    logic [63:0] sat_rxd_out;
    logic [7:0]  sat_rxc_out;
    logic        sat_local_fault;
    logic        sat_remote_fault;
    logic [1:0]  sat_fault_cnt;

    int num_checks = 0;
    int num_passed = 0;

    always #5 clk156 = ~clk156;

    xgmii_link_fault dut (
        .clk156        (clk156),
        .reset         (reset),
        .rx_reset      (rx_reset),
        .xgmii_rxd     (xgmii_rxd),
        .xgmii_rxc     (xgmii_rxc),
        .xgmii_rxd_out (xgmii_rxd_out),
        .xgmii_rxc_out (xgmii_rxc_out),
        .local_fault   (local_fault),
        .remote_fault  (remote_fault),
        .fault_cnt     (fault_cnt),
        .clr_cnt       (clr_cnt)
    );

    xgmii_link_fault #(.C_COL_WINDOW(128), .C_CNT_W(2)) dut_sat (
        .clk156        (clk156),
        .reset         (reset),
        .rx_reset      (rx_reset),
        .xgmii_rxd     (xgmii_rxd),
        .xgmii_rxc     (xgmii_rxc),
        .xgmii_rxd_out (sat_rxd_out),
        .xgmii_rxc_out (sat_rxc_out),
        .local_fault   (sat_local_fault),
        .remote_fault  (sat_remote_fault),
        .fault_cnt     (sat_fault_cnt),
        .clr_cnt       (clr_cnt)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        num_checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end else begin
            num_passed++;
        end
    endtask

    // Drive one cycle of two columns and return just after the capturing edge.
    task automatic applyStimulus(input logic [35:0] col_a, input logic [35:0] col_b);
        xgmii_rxd = {col_b[31:0], col_a[31:0]};
        xgmii_rxc = {col_b[35:32], col_a[35:32]};
        @(posedge clk156);
        #1;
    endtask

    initial begin
        logic seen_fault;

        reset     = 1'b1;
        rx_reset  = 1'b0;
        clr_cnt   = 1'b0;
        xgmii_rxd = {COL_IDLE[31:0], COL_IDLE[31:0]};
        xgmii_rxc = 8'hFF;
        repeat (2) @(posedge clk156);
        #1;
        checkOutput("reset_local", 64'(local_fault), 64'd0);
        checkOutput("reset_remote", 64'(remote_fault), 64'd0);
        checkOutput("reset_cnt", 64'(fault_cnt), 64'd0);
        checkOutput("reset_sat_cnt", 64'(sat_fault_cnt), 64'd0);
        checkOutput("reset_rxd_out", xgmii_rxd_out, IDLE_WORD);
        checkOutput("reset_rxc_out", 64'(xgmii_rxc_out), 64'hFF);
        reset = 1'b0;

        // Four LOCAL sequences in column A, idle in B
        for (int i = 0; i < 4; i++) begin
            applyStimulus(COL_LOCAL, COL_IDLE);
            if (i == 2) checkOutput("colA_3rd_no_fault", 64'(local_fault), 64'd0);
        end
        checkOutput("colA_4th_local", 64'(local_fault), 64'd1);
        checkOutput("colA_4th_remote", 64'(remote_fault), 64'd0);
        checkOutput("colA_4th_cnt", 64'(fault_cnt), 64'd1);

        // 127 non-sequence columns then LOCAL keeps the fault
        applyStimulus(COL_LOCAL, COL_LOCAL);
        for (int i = 0; i < 63; i++) begin
            applyStimulus(COL_IDLE, (i % 2 == 1) ? COL_BAD : COL_IDLE);
        end
        applyStimulus(COL_IDLE, COL_LOCAL);
        checkOutput("hold_after_127", 64'(local_fault), 64'd1);

        // 128 idle columns clear it
        for (int i = 0; i < 63; i++) applyStimulus(COL_IDLE, COL_IDLE);
        checkOutput("hold_after_126", 64'(local_fault), 64'd1);
        applyStimulus(COL_IDLE, COL_IDLE);
        checkOutput("clear_after_128", 64'(local_fault), 64'd0);
        checkOutput("clear_cnt_kept", 64'(fault_cnt), 64'd1);

        // Two LOCAL sequences per cycle
        applyStimulus(COL_LOCAL, COL_LOCAL);
        checkOutput("dual_cycle1", 64'(local_fault), 64'd0);
        applyStimulus(COL_LOCAL, COL_LOCAL);
        checkOutput("dual_cycle2", 64'(local_fault), 64'd1);
        checkOutput("dual_cnt", 64'(fault_cnt), 64'd2);

        // LOCAL -> REMOTE while faulted
        applyStimulus(COL_REMOTE, COL_REMOTE);
        checkOutput("l2r_local_retained", 64'(local_fault), 64'd1);
        checkOutput("l2r_remote_pending", 64'(remote_fault), 64'd0);
        applyStimulus(COL_REMOTE, COL_REMOTE);
        checkOutput("l2r_remote", 64'(remote_fault), 64'd1);
        checkOutput("l2r_local", 64'(local_fault), 64'd0);
        checkOutput("l2r_cnt", 64'(fault_cnt), 64'd3);
        checkOutput("l2r_sat_cnt", 64'(sat_fault_cnt), 64'd3);
        applyStimulus(COL_LOCAL, COL_LOCAL);
        applyStimulus(COL_LOCAL, COL_LOCAL);
        checkOutput("r2l_local", 64'(local_fault), 64'd1);
        checkOutput("r2l_cnt", 64'(fault_cnt), 64'd4);
        checkOutput("sat_held", 64'(sat_fault_cnt), 64'd3);

        // clr_cnt wins over a simultaneous fault declaration
        applyStimulus(COL_REMOTE, COL_REMOTE);
        clr_cnt = 1'b1;
        applyStimulus(COL_REMOTE, COL_REMOTE);
        clr_cnt = 1'b0;
        checkOutput("clr_remote", 64'(remote_fault), 64'd1);
        checkOutput("clr_priority_cnt", 64'(fault_cnt), 64'd0);
        checkOutput("clr_priority_sat", 64'(sat_fault_cnt), 64'd0);
        applyStimulus(COL_LOCAL, COL_LOCAL);
        applyStimulus(COL_LOCAL, COL_LOCAL);
        checkOutput("cnt_after_clr", 64'(fault_cnt), 64'd1);

        // rx_reset clears everything, including the delayed RX data
        rx_reset = 1'b1;
        applyStimulus(COL_LOCAL, COL_LOCAL);
        rx_reset = 1'b0;
        checkOutput("rxrst_local", 64'(local_fault), 64'd0);
        checkOutput("rxrst_cnt", 64'(fault_cnt), 64'd0);
        checkOutput("rxrst_rxd_out", xgmii_rxd_out, IDLE_WORD);
        checkOutput("rxrst_rxc_out", 64'(xgmii_rxc_out), 64'hFF);

        // Alternating LOCAL/REMOTE columns never reach four in a row
        seen_fault = 1'b0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(COL_LOCAL, COL_REMOTE);
            seen_fault = seen_fault | local_fault | remote_fault;
        end
        checkOutput("alternating_no_fault", 64'(seen_fault), 64'd0);

        // rx_reset between the 3rd and 4th LOCAL discards the partial count
        for (int i = 0; i < 3; i++) applyStimulus(COL_LOCAL, COL_IDLE);
        rx_reset = 1'b1;
        applyStimulus(COL_IDLE, COL_IDLE);
        rx_reset = 1'b0;
        applyStimulus(COL_LOCAL, COL_IDLE);
        checkOutput("partial_discard_local", 64'(local_fault), 64'd0);
        checkOutput("partial_discard_remote", 64'(remote_fault), 64'd0);
        checkOutput("partial_discard_cnt", 64'(fault_cnt), 64'd0);

        // RX data passes through with exactly one cycle of latency
        xgmii_rxd = 64'h0123456789ABCDEF;
        xgmii_rxc = 8'h00;
        @(posedge clk156);
        #1;
        checkOutput("rxd_lat_1", xgmii_rxd_out, 64'h0123456789ABCDEF);
        checkOutput("rxc_lat_1", 64'(xgmii_rxc_out), 64'h00);
        xgmii_rxd = 64'hFEDCBA9876543210;
        xgmii_rxc = 8'h5A;
        #2;
        checkOutput("rxd_lat_hold", xgmii_rxd_out, 64'h0123456789ABCDEF);
        checkOutput("rxc_lat_hold", 64'(xgmii_rxc_out), 64'h00);
        @(posedge clk156);
        #1;
        checkOutput("rxd_lat_2", xgmii_rxd_out, 64'hFEDCBA9876543210);
        checkOutput("rxc_lat_2", 64'(xgmii_rxc_out), 64'h5A);

        $display("%0d/%0d checks passed", num_passed, num_checks);
        $finish;
    end

endmodule
